// File: rtl/image_write.sv
// -----------------------------------------------------------------------------
// image_write
//   Receiving end of a two-pixels-per-clock RGB888 stream. One frame is
//   captured into an internal byte buffer in BMP layout (rows bottom-up,
//   bytes B,G,R per pixel) and can be drained through a registered read port.
//
// Ports
//   HCLK, HRESET         clock, asynchronous active-high reset
//   VSYNC                frame arm (any state, highest priority)
//   HSYNC                pixel pair valid this cycle
//   DATA_{R,G,B}0        even pixel (column col)
//   DATA_{R,G,B}1        odd pixel  (column col+1)
//   rd_addr / rd_data    byte read port, 1-cycle latency, 0 when out of range
//   write_done           level, frame fully captured
//   line_err             sticky, HSYNC dropped in the middle of a line
//   pair_count           pairs written in the current frame (saturating)
//
// Handshake: the stream has no back-pressure. A pair is consumed on every
// rising HCLK edge where HSYNC=1 and VSYNC=0 while the FSM is ARMED or
// CAPTURE; in IDLE and DONE HSYNC is ignored.
// -----------------------------------------------------------------------------
module image_write #(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter     OUTFILE = "output.bmp"
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic [7:0]  DATA_R0,
  input  logic [7:0]  DATA_G0,
  input  logic [7:0]  DATA_B0,
  input  logic [7:0]  DATA_R1,
  input  logic [7:0]  DATA_G1,
  input  logic [7:0]  DATA_B1,
  input  logic [20:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        write_done,
  output logic        line_err,
  output logic [18:0] pair_count
);

  localparam int LINE_BYTES = WIDTH * 3;
  localparam int DEPTH      = WIDTH * HEIGHT * 3;
  localparam int AW         = $clog2(DEPTH);
  localparam int ROW_W      = $clog2(HEIGHT + 1);
  localparam int COL_W      = $clog2(WIDTH + 1);

  localparam logic [20:0]      DEPTH_A  = 21'(DEPTH);
  localparam logic [18:0]      PAIRS    = 19'(WIDTH * HEIGHT / 2);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [18:0]      pair_count_q, pair_count_d;
  logic             write_done_q, write_done_d;
  logic             line_err_q, line_err_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic             wr_en;
  logic [AW-1:0]    wr_base;

  logic [7:0]       mem [0:DEPTH-1];

  // Byte address of the even pixel; rows are stored bottom-up.
  assign wr_base = AW'(LINE_BYTES * (HEIGHT - 1 - int'(row_q)) + 3 * int'(col_q));

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    pair_count_d = pair_count_q;
    write_done_d = write_done_q;
    line_err_d   = line_err_q;
    wr_en        = 1'b0;

    if (VSYNC) begin
      state_d      = S_ARMED;
      row_d        = '0;
      col_d        = '0;
      pair_count_d = '0;
      write_done_d = 1'b0;
      line_err_d   = 1'b0;
    end else if ((state_q == S_ARMED) || (state_q == S_CAPTURE)) begin
      if (HSYNC) begin
        // ARMED always sits at row 0 / col 0, so the first pair shares the
        // same advance logic as every later pair.
        wr_en        = 1'b1;
        state_d      = S_CAPTURE;
        pair_count_d = (pair_count_q == PAIRS) ? pair_count_q : pair_count_q + 19'd1;
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            state_d      = S_DONE;
            write_done_d = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(2);
        end
      end else if ((state_q == S_CAPTURE) && (col_q != '0)) begin
        line_err_d = 1'b1;
      end
    end

    // Same-cycle read/write to one byte returns the old contents because the
    // buffer update is a non-blocking write on the same edge.
    rd_data_d = (rd_addr < DEPTH_A) ? mem[rd_addr[AW-1:0]] : 8'h00;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      pair_count_q <= '0;
      write_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pair_count_q <= pair_count_d;
      write_done_q <= write_done_d;
      line_err_q   <= line_err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Frame buffer is deliberately not reset; partial data survives HRESET.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      mem[wr_base]          <= DATA_B0;
      mem[wr_base + AW'(1)] <= DATA_G0;
      mem[wr_base + AW'(2)] <= DATA_R0;
      mem[wr_base + AW'(3)] <= DATA_B1;
      mem[wr_base + AW'(4)] <= DATA_G1;
      mem[wr_base + AW'(5)] <= DATA_R1;
    end
  end

  assign rd_data    = rd_data_q;
  assign write_done = write_done_q;
  assign line_err   = line_err_q;
  assign pair_count = pair_count_q;

endmodule
